alu_share_ctrl: RTL and testbench

Sequencer and two-port arbiter that shares the single 64-bit combinational ALU between two requesters. It accepts one operation at a time through a valid/ready request port and drives the ALU's operand, opcode and carry inputs from registers. It waits a configurable number of settle cycles, then captures the ALU output and returns it, tagged with the requester ID, on a valid/ready response port. It sits between the datapath issue logic and the ALU instance.

---
 rtl/alu_share_ctrl.sv | 105 ++++++++++
 tb/tb_alu_share_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin two-port sequencer sharing one combinational 64-bit ALU
//   Parameter ALU_LAT (1..15): settle cycles between driving the ALU and capturing alu_fout.
//   Optional macro ALU_SHARE_FLAGS_EN adds registered rsp_zero / rsp_neg result flags.
//   Ports:
//     clk, rst_n                 clock (rising edge), asynchronous active-low reset
//     reqN_valid/ready           request handshake for requester N (0/1)
//     reqN_a/b/op/cin            request operands, ALU opcode, carry-in
//     alu_a/b/fsec/carry         registered ALU inputs, held from one acceptance to the next
//     alu_fout                   combinational ALU result
//     rsp_valid/ready            response handshake
//     rsp_id, rsp_result         requester tag and captured ALU result
//     rsp_zero, rsp_neg          result flags (ALU_SHARE_FLAGS_EN only)
//     busy                       high whenever an operation is in flight or awaiting pickup
module alu_share_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [4:0]  req0_op,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [4:0]  req1_op,
    input  logic        req1_cin,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [4:0]  alu_fsec,
    output logic        alu_carry,
    input  logic [63:0] alu_fout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
`ifdef ALU_SHARE_FLAGS_EN
    output logic        rsp_zero,
    output logic        rsp_neg,
`endif
    output logic        busy
);
    localparam logic [3:0] LAT = 4'(ALU_LAT);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic       last_grant;
    logic       win;
    logic       accept;
    logic       capture;
    // On a tie the requester that did not win last time goes first; otherwise the lone valid wins.
    always_comb begin
        win        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        req0_ready = (state == IDLE) & req0_valid & ~win;
        req1_ready = (state == IDLE) & req1_valid & win;
        accept     = req0_ready | req1_ready;
        capture    = (state == EXEC) & (cnt == 4'd1);
        state_nxt  = accept                         ? EXEC :
                     capture                        ? RESP :
                     (state == RESP) & rsp_ready    ? IDLE : state;
        rsp_valid  = state == RESP;
        busy       = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_fsec   <= '0;
            alu_carry  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
        end else if (accept) begin
            cnt        <= LAT;
            last_grant <= win;
            alu_a      <= win ? req1_a   : req0_a;
            alu_b      <= win ? req1_b   : req0_b;
            alu_fsec   <= win ? req1_op  : req0_op;
            alu_carry  <= win ? req1_cin : req0_cin;
            rsp_id     <= win;
        end else if (state == EXEC) begin
            cnt        <= cnt - 4'd1;
            if (capture) rsp_result <= alu_fout;
        end
    end
`ifdef ALU_SHARE_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero <= 1'b0;
            rsp_neg  <= 1'b0;
        end else if (capture) begin
            rsp_zero <= alu_fout == 64'd0;
            rsp_neg  <= alu_fout[63];
        end
    end
`endif
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: randomized self-checking bench for alu_share_ctrl with a behavioural ALU
module tb_alu_share_ctrl;
    localparam int LAT = 3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req0_cin;
    logic        req1_valid, req1_ready, req1_cin;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_op, req1_op;
    logic [63:0] alu_a, alu_b, alu_fout, rsp_result;
    logic [4:0]  alu_fsec;
    logic        alu_carry, rsp_valid, rsp_ready, rsp_id, busy;
`ifdef ALU_SHARE_FLAGS_EN
    logic        rsp_zero, rsp_neg;
`endif
    int vec = 0;
    int errs = 0;
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [4:0] op, input logic c);
        case (op)
            5'h00:   return a + b + {63'd0, c};
            5'h01:   return a - b;
            5'h02:   return a & b;
            5'h03:   return a | b;
            5'h04:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    assign alu_fout = alu_f(alu_a, alu_b, alu_fsec, alu_carry);

    alu_share_ctrl #(.ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fsec(alu_fsec), .alu_carry(alu_carry),
        .alu_fout(alu_fout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
`ifdef ALU_SHARE_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
        .busy(busy)
    );

    // Drives one request and returns just after the edge that accepted it (ok=0 if never accepted).
    task automatic accept(input bit id, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] op, input logic c, output bit ok);
        ok = 1'b0;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_cin = c; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_cin = c; req0_valid = 1'b1;
        end
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vec++;
        if ({busy, rsp_valid, rsp_id, req0_ready, req1_ready} !== 5'b0 || rsp_result !== 64'd0)
            begin errs++; $display("FAIL reset_outputs: busy=%b rsp_valid=%b rsp_id=%b rdy=%b%b result=%h, required all 0",
                     busy, rsp_valid, rsp_id, req0_ready, req1_ready, rsp_result); end
        vec++;
        if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_fsec !== 5'd0 || alu_carry !== 1'b0)
            begin errs++; $display("FAIL reset_alu: a=%h b=%h fsec=%h carry=%b, required 0", alu_a, alu_b, alu_fsec, alu_carry); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bit ok;
        accept(1'b0, 64'h5, 64'h3, 5'h00, 1'b1, ok);
        vec++;
        if (!ok) begin errs++; $display("FAIL single_accept: not accepted, required accepted"); end
        for (int k = 1; k <= LAT; k++) begin
            vec++;
            if (rsp_valid !== 1'b0 || busy !== 1'b1 || alu_a !== 64'h5 || alu_b !== 64'h3 || alu_carry !== 1'b1)
                begin errs++; $display("FAIL single_exec%0d: rsp_valid=%b busy=%b a=%h b=%h, required 0 1 5 3", k, rsp_valid, busy, alu_a, alu_b); end
            @(posedge clk);
            #1;
        end
        vec++;
        if (rsp_valid !== 1'b1 || rsp_result !== 64'h9 || rsp_id !== 1'b0)
            begin errs++; $display("FAIL single_rsp: valid=%b result=%h id=%b, required 1 9 0", rsp_valid, rsp_result, rsp_id); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            begin errs++; $display("FAIL single_done: valid=%b busy=%b, required 0 0", rsp_valid, busy); end
    endtask

    task automatic test_tie();
        logic [63:0] pa[2], pb[2];
        logic [4:0]  pop[2];
        logic        pc[2];
        logic [63:0] er;
        bit exp_w = 1'b0;
        int acc = 0;
        int t;
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            pa[i] = r64(); pb[i] = r64(); pop[i] = 5'($urandom_range(0, 7)); pc[i] = 1'($urandom);
        end
        rsp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0]; req0_cin = pc[0];
            req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1]; req1_cin = pc[1];
            req0_valid = 1'b1; req1_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && t < 20) begin @(negedge clk); t++; end
            vec++;
            if ({req1_ready, req0_ready} !== (exp_w ? 2'b10 : 2'b01))
                begin errs++; $display("FAIL tie_grant%0d: ready1/0=%b%b, required winner %0d", g, req1_ready, req0_ready, exp_w); end
            er = alu_f(pa[exp_w], pb[exp_w], pop[exp_w], pc[exp_w]);
            @(posedge clk);
            #1;
            if (g > 0) begin
                vec++;
                if (cyc - acc != LAT + 2)
                    begin errs++; $display("FAIL tie_interval%0d: %0d cycles, required %0d", g, cyc - acc, LAT + 2); end
            end
            acc = cyc;
            pa[exp_w] = r64(); pb[exp_w] = r64(); pop[exp_w] = 5'($urandom_range(0, 7)); pc[exp_w] = 1'($urandom);
            if (exp_w) begin req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1]; req1_cin = pc[1]; end
            else       begin req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0]; req0_cin = pc[0]; end
            repeat (LAT) @(posedge clk);
            #1;
            vec++;
            if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_id !== exp_w)
                begin errs++; $display("FAIL tie_rsp%0d: valid=%b result=%h id=%b, required 1 %h %0d", g, rsp_valid, rsp_result, rsp_id, er, exp_w); end
            exp_w = ~exp_w;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [63:0] a = r64();
        logic [63:0] b = r64();
        logic [63:0] er = alu_f(a, b, 5'h01, 1'b0);
        accept(1'b1, a, b, 5'h01, 1'b0, ok);
        vec++;
        if (!ok) begin errs++; $display("FAIL bp_accept: not accepted, required accepted"); end
        repeat (LAT) @(posedge clk);
        #1 req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = r64(); req1_a = r64();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vec++;
            if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_id !== 1'b1 || req0_ready !== 1'b0 ||
                req1_ready !== 1'b0 || busy !== 1'b1 || alu_a !== a)
                begin errs++; $display("FAIL bp_hold%0d: valid=%b result=%h id=%b rdy=%b%b busy=%b alu_a=%h, required 1 %h 1 00 1 %h",
                         k, rsp_valid, rsp_result, rsp_id, req0_ready, req1_ready, busy, alu_a, er, a); end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            begin errs++; $display("FAIL bp_release: valid=%b busy=%b, required 0 0", rsp_valid, busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [63:0] a = r64();
        logic [63:0] b = r64();
        accept(1'b0, r64() | 64'd1, r64(), 5'h02, 1'b1, ok);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vec++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_a !== 64'd0 || alu_fsec !== 5'd0)
            begin errs++; $display("FAIL rstmid_async: busy=%b valid=%b alu_a=%h fsec=%h, required 0 0 0 0", busy, rsp_valid, alu_a, alu_fsec); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(posedge clk);
            #1;
            vec++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0)
                begin errs++; $display("FAIL rstmid_stale%0d: valid=%b busy=%b, required 0 0", k, rsp_valid, busy); end
        end
        accept(1'b1, a, b, 5'h00, 1'b0, ok);
        repeat (LAT) @(posedge clk);
        #1;
        vec++;
        if (!ok || rsp_valid !== 1'b1 || rsp_result !== a + b || rsp_id !== 1'b1)
            begin errs++; $display("FAIL rstmid_next: ok=%b valid=%b result=%h id=%b, required 1 1 %h 1", ok, rsp_valid, rsp_result, rsp_id, a + b); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

`ifdef ALU_SHARE_FLAGS_EN
    task automatic test_flags();
        bit ok;
        accept(1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 5'h00, 1'b0, ok);
        repeat (LAT) @(posedge clk);
        #1;
        vec++;
        if (rsp_valid !== 1'b1 || rsp_result !== 64'd0 || rsp_zero !== 1'b1 || rsp_neg !== 1'b0)
            begin errs++; $display("FAIL flags_zero: valid=%b result=%h zero=%b neg=%b, required 1 0 1 0", rsp_valid, rsp_result, rsp_zero, rsp_neg); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        accept(1'b0, 64'h8000_0000_0000_0000, 64'd0, 5'h00, 1'b0, ok);
        repeat (LAT) @(posedge clk);
        #1;
        vec++;
        if (rsp_valid !== 1'b1 || rsp_zero !== 1'b0 || rsp_neg !== 1'b1)
            begin errs++; $display("FAIL flags_neg: valid=%b zero=%b neg=%b, required 1 0 1", rsp_valid, rsp_zero, rsp_neg); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask
`endif

    // Transaction-level model: a single in-flight slot with a countdown to its response,
    // round-robin pick on ties, ALU inputs remembered from the last acceptance.
    task automatic test_random();
        logic [63:0] pa[2], pb[2];
        logic [4:0]  pop[2];
        logic        pc[2];
        bit v[2];
        bit m_last = 1'b1;
        bit m_rsp = 1'b0;
        int m_wait = 0;
        logic [63:0] m_res = '0;
        logic [63:0] m_a = '0;
        logic [4:0]  m_op = '0;
        bit m_id = 1'b0;
        bit idle, w, acc, er0, er1;
        pulse_reset();
        v[0] = 1'b0; v[1] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++)
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i] = 1'b1; pa[i] = r64(); pb[i] = r64();
                    pop[i] = 5'($urandom_range(0, 7)); pc[i] = 1'($urandom);
                end
            req0_valid = v[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0]; req0_cin = pc[0];
            req1_valid = v[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1]; req1_cin = pc[1];
            rsp_ready = 1'($urandom);
            @(negedge clk);
            idle = !m_rsp && m_wait == 0;
            w    = (v[0] && v[1]) ? !m_last : v[1];
            er0  = idle && v[0] && !w;
            er1  = idle && v[1] && w;
            acc  = er0 || er1;
            vec++;
            if ({req1_ready, req0_ready} !== {er1, er0})
                begin errs++; $display("FAIL rnd_ready@%0d: ready1/0=%b%b, required %b%b", n, req1_ready, req0_ready, er1, er0); end
            vec++;
            if (busy !== !idle || rsp_valid !== m_rsp)
                begin errs++; $display("FAIL rnd_state@%0d: busy=%b valid=%b, required %b %b", n, busy, rsp_valid, !idle, m_rsp); end
            vec++;
            if (alu_a !== m_a || alu_fsec !== m_op)
                begin errs++; $display("FAIL rnd_alu_hold@%0d: a=%h fsec=%h, required %h %h", n, alu_a, alu_fsec, m_a, m_op); end
            if (m_rsp) begin
                vec++;
                if (rsp_result !== m_res || rsp_id !== m_id)
                    begin errs++; $display("FAIL rnd_rsp@%0d: result=%h id=%b, required %h %b", n, rsp_result, rsp_id, m_res, m_id); end
`ifdef ALU_SHARE_FLAGS_EN
                vec++;
                if (rsp_zero !== (m_res == 64'd0) || rsp_neg !== m_res[63])
                    begin errs++; $display("FAIL rnd_flags@%0d: zero=%b neg=%b, required %b %b", n, rsp_zero, rsp_neg, m_res == 64'd0, m_res[63]); end
`endif
            end
            @(posedge clk);
            #1;
            if (m_rsp) begin
                if (rsp_ready) m_rsp = 1'b0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_rsp = 1'b1;
            end else if (acc) begin
                m_wait = LAT;
                m_res  = alu_f(pa[w], pb[w], pop[w], pc[w]);
                m_a    = pa[w];
                m_op   = pop[w];
                m_id   = w;
                m_last = w;
                v[w]   = 1'b0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        #1 rsp_ready = 1'b0;
        vec++;
        if (busy !== 1'b0) begin errs++; $display("FAIL rnd_drain: busy=%b, required 0", busy); end
    endtask

    initial begin
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_cin = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_reset_mid();
`ifdef ALU_SHARE_FLAGS_EN
        test_flags();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
